mileage_counter: RTL and testbench
==================================

# mileage_counter

Odometer stage that produces the 27-bit binary mileage word consumed by the mileage display top (`record` input there). It converts "car is moving" time into distance units with a prescaler, accumulates a saturating trip total, and supports trip clear via a front-panel button and clear-on-power-off. All outputs are registered, so the downstream digit split sees a stable value between increments.

## Interface

Parameters:
- `TICK_DIV`, 100_000_000: clock cycles of motion per distance unit; must be ≥ 2.
- `MAX_RECORD`, 99_999_999: saturation ceiling, the 8-digit display limit; must be < 2^27.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `power_now`  in  1  car power state, synchronous to `clk`; 1 = powered.
- `moving`  in  1  drive FSM motion flag, synchronous to `clk`; 1 = car in motion.
- `clr_btn`  in  1  trip-clear button, asynchronous and already debounced; active-high.
- `record`  out  27  accumulated mileage in units, binary.
- `unit_tick`  out  1  one-cycle pulse on each increment of `record`.
- `sat`  out  1  high while `record == MAX_RECORD`.
- `odo_state`  out  2  current FSM state.

## Operation

- FSM states: OFF = 2'd0, STOP = 2'd1, RUN = 2'd2. Encoding 2'd3 is unused and recovers to OFF on the next edge.
- Transitions are evaluated every cycle, in priority order:
  - `~power_now` → OFF.
  - else `moving` → RUN.
  - else → STOP.
- Prescaler `pre`, width clog2(TICK_DIV):
  - RUN: `pre` counts 0..TICK_DIV-1 and wraps.
  - STOP: `pre` holds, so partial distance is retained across stops.
  - OFF: `pre` is forced to 0.
- Increment: in RUN with `pre == TICK_DIV-1`, on the next edge `pre` becomes 0. Then:
  - if `record < MAX_RECORD`: `record` becomes `record`+1 and `unit_tick` = 1 for that cycle.
  - if `record == MAX_RECORD`: `record` holds and `unit_tick` stays 0; the prescaler still wraps.
- Power-off clear: on the edge where state becomes OFF, `record` becomes 0. `record` stays 0 for as long as the block is in OFF.
- Trip clear: a rising edge of the synchronised `clr_btn` forces `record` and `pre` to 0. The state is unchanged.
- Simultaneous events:
  - clear and increment in the same cycle: clear wins, `record` = 0 and `unit_tick` = 0.
  - clear while OFF: no additional effect.
- `sat` is registered and equals (`record == MAX_RECORD`) for the value being driven; it drops the cycle `record` is cleared.

## Timing

- Reset (async assert): `record` = 0, `unit_tick` = 0, `sat` = 0, `odo_state` = OFF, `pre` = 0, sync flops = 0.
- Reset release: the first state update occurs on the first rising edge of `clk` after `rst_n` goes high.
- Reset asserted mid-count: takes effect immediately, with no wait for an edge; partial distance is lost.
- State latency: `odo_state` reflects `power_now`/`moving` one edge after they change.
- Motion to first increment: entering RUN with `pre` = 0, `record` increments on the TICK_DIV-th edge after the edge that entered RUN.
- `clr_btn` path: 2-flop synchroniser plus an edge register. `record` reads 0 after the 3rd rising edge following the `clr_btn` rise. A held button clears exactly once.
- `unit_tick` rises and falls on the same edges as the `record` increment it marks, and lasts exactly 1 cycle.
- No handshake: the downstream stage samples `record` freely. `record` changes at most once per TICK_DIV cycles, except for clears.

## Structure

- Shared package `odo_pkg`:
  - state localparams `ODO_OFF`, `ODO_STOP`, `ODO_RUN`.
  - `RECORD_W` = 27.
  - default `MAX_RECORD`.
- Sub-module `btn_sync_edge`: 2-flop synchroniser plus registered rising-edge detector, with async active-low reset. It is reused by the other front-panel buttons.
- Top body contains the FSM, the prescaler and the saturating accumulator.

## Test plan

Bench uses TICK_DIV=4 and MAX_RECORD=10.

1. Reset with power_now=1 and moving=1 held → release reset.
   - Expect: `odo_state` = RUN after 1 edge.
   - Expect: `record` = 1 with a `unit_tick` pulse 4 edges after entering RUN, then `record` = 5 after 20 edges total in RUN.
2. In RUN, drop `moving` when `pre` = 2, hold 10 cycles, then reassert.
   - Expect: `record` unchanged during STOP.
   - Expect: next increment 2 edges after re-entering RUN.
3. Run until `record` = 10.
   - Expect: `sat` = 1, `record` stays 10, no `unit_tick` for 20 further cycles.
4. `record` = 7, assert `clr_btn` for 50 cycles.
   - Expect: `record` = 0 and `pre` = 0 on the 3rd edge after the rise.
   - Expect: exactly one clear; counting resumes while the button is still held.
5. Clear edge aligned with the `pre` = 3 cycle in RUN.
   - Expect: `record` = 0 and `unit_tick` = 0 in that cycle.
6. `record` = 6, drop `power_now`.
   - Expect: OFF and `record` = 0 after 1 edge.
   - Expect: `record` stays 0 while OFF with `moving` toggling.
   - Then assert `rst_n` low mid-RUN: all outputs reset asynchronously.

Source files
------------

// File: rtl/odo_pkg.sv
// Shared odometer definitions: FSM encoding, mileage word width and default limits.
package odo_pkg;

  localparam int unsigned RECORD_W       = 27;
  localparam int unsigned MAX_RECORD_DEF = 99_999_999;
  localparam int unsigned TICK_DIV_DEF   = 100_000_000;

  typedef enum logic [1:0] {
    ODO_OFF  = 2'd0,
    ODO_STOP = 2'd1,
    ODO_RUN  = 2'd2
  } odo_state_e;

endpackage

// File: rtl/btn_sync_edge.sv
// Front-panel button conditioner: 2-flop synchroniser plus a history flop for rise detection.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise_c
);

  // [0] metastable stage, [1] synchronised level, [2] previous synchronised level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/mileage_counter.sv
// Odometer stage: motion-time prescaler feeding a saturating trip accumulator with
// power-off and front-panel clears. All outputs come straight from flops.
module mileage_counter
  import odo_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned MAX_RECORD = MAX_RECORD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                power_now,
  input  logic                moving,
  input  logic                clr_btn,
  output logic [RECORD_W-1:0] record,
  output logic                unit_tick,
  output logic                sat,
  output logic [1:0]          odo_state
);

  localparam int unsigned          PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]     PRE_TOP = PRE_W'(TICK_DIV - 1);
  localparam logic [RECORD_W-1:0]  REC_MAX = RECORD_W'(MAX_RECORD);

  odo_state_e          state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [RECORD_W-1:0] record_q, record_d;
  logic                unit_tick_q, unit_tick_d;
  logic                sat_q, sat_d;
  logic                clr_rise_c;
  logic                wrap_c;

  btn_sync_edge u_clr_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (clr_btn),
    .rise_c (clr_rise_c)
  );

  // Next state depends only on inputs; the unused encoding falls back to OFF.
  always_comb begin
    state_d = ODO_OFF;
    case (state_q)
      ODO_OFF, ODO_STOP, ODO_RUN: begin
        if (!power_now) begin
          state_d = ODO_OFF;
        end else if (moving) begin
          state_d = ODO_RUN;
        end else begin
          state_d = ODO_STOP;
        end
      end
      default: state_d = ODO_OFF;
    endcase
  end

  // Prescaler and accumulator; clears override any increment in the same cycle.
  always_comb begin
    wrap_c      = (state_q == ODO_RUN) && (pre_q == PRE_TOP);
    pre_d       = pre_q;
    record_d    = record_q;
    unit_tick_d = 1'b0;

    if (state_q == ODO_RUN) begin
      pre_d = wrap_c ? '0 : pre_q + PRE_W'(1);
    end

    if (wrap_c && (record_q < REC_MAX)) begin
      record_d    = record_q + RECORD_W'(1);
      unit_tick_d = 1'b1;
    end

    if (clr_rise_c || (state_d == ODO_OFF)) begin
      pre_d       = '0;
      record_d    = '0;
      unit_tick_d = 1'b0;
    end

    sat_d = (record_d == REC_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ODO_OFF;
      pre_q       <= '0;
      record_q    <= '0;
      unit_tick_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      record_q    <= record_d;
      unit_tick_q <= unit_tick_d;
      sat_q       <= sat_d;
    end
  end

  assign record    = record_q;
  assign unit_tick = unit_tick_q;
  assign sat       = sat_q;
  assign odo_state = state_q;

endmodule

// File: tb/tb_mileage_counter.sv
// Self-checking bench for mileage_counter with TICK_DIV=4, MAX_RECORD=10.
module tb_mileage_counter;
  import odo_pkg::*;

  localparam int unsigned TD = 4;
  localparam int unsigned MR = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        power_now = 1'b0;
  logic        moving = 1'b0;
  logic        clr_btn = 1'b0;
  logic [26:0] record;
  logic        unit_tick;
  logic        sat;
  logic [1:0]  odo_state;

  mileage_counter #(.TICK_DIV(TD), .MAX_RECORD(MR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .power_now (power_now),
    .moving    (moving),
    .clr_btn   (clr_btn),
    .record    (record),
    .unit_tick (unit_tick),
    .sat       (sat),
    .odo_state (odo_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [26:0] rec;
    logic        tick;
    logic        sat;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(int r, logic t, logic s, logic [1:0] st);
    exp_t e;
    e.rec  = 27'(r);
    e.tick = t;
    e.sat  = s;
    e.st   = st;
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t e;
    e.rec  = record;
    e.tick = unit_tick;
    e.sat  = sat;
    e.st   = odo_state;
    return e;
  endfunction

  // Expected outputs k edges into RUN, starting from pre=0 and record=r0.
  function automatic exp_t run_exp(int r0, int k);
    int v;
    int r;
    v = r0 + k / int'(TD);
    r = (v > int'(MR)) ? int'(MR) : v;
    return mk(r, (k > 0) && (k % int'(TD) == 0) && (v <= int'(MR)), r == int'(MR), ODO_RUN);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e, g;
    power_now = 1'b1;
    moving    = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    sb.push_back(mk(0, 1'b0, 1'b0, ODO_OFF));
    g = obs(); e = sb.pop_front(); total++;
    if (g !== e) begin
      bad++;
      $display("FAIL reset_state: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
               g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
    end
    rst_n = 1'b1;
    sb.push_back(mk(0, 1'b0, 1'b0, ODO_RUN));
    step();
    g = obs(); e = sb.pop_front(); total++;
    if (g !== e) begin
      bad++;
      $display("FAIL reset_release: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
               g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
    end
  endtask

  task automatic test_first_increment();
    exp_t e, g;
    for (int k = 1; k <= 20; k++) begin
      sb.push_back(run_exp(0, k));
      step();
      g = obs(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL first_inc k=%0d: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
                 k, g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
      end
    end
  endtask

  task automatic test_stop_resume();
    exp_t e, g;
    sb.push_back(run_exp(5, 1));
    moving = 1'b1;
    step();
    moving = 1'b0;
    for (int i = 0; i < 11; i++) sb.push_back(mk(5, 1'b0, 1'b0, ODO_STOP));
    repeat (12) begin
      g = obs(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL stop_hold: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
                 g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
      end
      if (sb.size() != 0) step();
    end
    moving = 1'b1;
    sb.push_back(mk(5, 1'b0, 1'b0, ODO_RUN));
    sb.push_back(mk(5, 1'b0, 1'b0, ODO_RUN));
    sb.push_back(mk(6, 1'b1, 1'b0, ODO_RUN));
    for (int i = 0; i < 3; i++) begin
      step();
      g = obs(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL resume i=%0d: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
                 i, g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
      end
    end
  endtask

  task automatic test_power_off();
    exp_t e, g;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) power_now = 1'b0;
      else if (i < 9) moving = ~moving;
      else begin
        power_now = 1'b1;
        moving    = 1'b1;
      end
      sb.push_back(mk(0, 1'b0, 1'b0, (i == 9) ? ODO_RUN : ODO_OFF));
      step();
      g = obs(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL power_off i=%0d: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
                 i, g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e, g;
    for (int k = 1; k <= 60; k++) begin
      sb.push_back(run_exp(0, k));
      step();
      g = obs(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL saturate k=%0d: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
                 k, g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
      end
    end
  endtask

  task automatic test_clear_hold();
    exp_t e, g;
    power_now = 1'b0;
    sb.push_back(mk(0, 1'b0, 1'b0, ODO_OFF));
    step();
    power_now = 1'b1;
    sb.push_back(mk(0, 1'b0, 1'b0, ODO_RUN));
    for (int k = 1; k <= 28; k++) sb.push_back(run_exp(0, k));
    for (int i = 0; i < 30; i++) begin
      if (i > 0) step();
      g = obs(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL to_seven i=%0d: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
                 i, g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
      end
    end
    clr_btn = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      sb.push_back((k < 3) ? run_exp(7, k) : run_exp(0, k - 3));
      step();
      g = obs(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL clear_hold k=%0d: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
                 k, g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
      end
      if (k == 3) begin
        total++;
        if (dut.pre_q !== 2'd0) begin
          bad++;
          $display("FAIL clear_pre: got pre=%0d want pre=0", dut.pre_q);
        end
      end
    end
  endtask

  task automatic test_clear_vs_increment();
    exp_t e, g;
    clr_btn   = 1'b0;
    power_now = 1'b0;
    sb.push_back(mk(0, 1'b0, 1'b0, ODO_OFF));
    step();
    power_now = 1'b1;
    sb.push_back(mk(0, 1'b0, 1'b0, ODO_RUN));
    for (int k = 1; k <= 5; k++) sb.push_back(run_exp(0, k));
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      g = obs(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL pre_align i=%0d: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
                 i, g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
      end
    end
    // Button rises with pre=1 so the detected edge lands on the pre=3 cycle.
    clr_btn = 1'b1;
    sb.push_back(run_exp(0, 6));
    sb.push_back(run_exp(0, 7));
    sb.push_back(mk(0, 1'b0, 1'b0, ODO_RUN));
    for (int k = 1; k <= 4; k++) sb.push_back(run_exp(0, k));
    for (int i = 0; i < 7; i++) begin
      step();
      g = obs(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL clr_vs_inc i=%0d: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
                 i, g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
      end
    end
    clr_btn = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e, g;
    for (int k = 1; k <= 2; k++) begin
      sb.push_back(run_exp(1, k));
      step();
      g = obs(); e = sb.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL pre_reset k=%0d: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
                 k, g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(mk(0, 1'b0, 1'b0, ODO_OFF));
    g = obs(); e = sb.pop_front(); total++;
    if (g !== e) begin
      bad++;
      $display("FAIL async_reset: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
               g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
    end
    total++;
    if (dut.pre_q !== 2'd0) begin
      bad++;
      $display("FAIL async_reset_pre: got pre=%0d want pre=0", dut.pre_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(0, 1'b0, 1'b0, ODO_RUN));
    step();
    g = obs(); e = sb.pop_front(); total++;
    if (g !== e) begin
      bad++;
      $display("FAIL rerelease: got rec=%0d tick=%b sat=%b st=%0d want rec=%0d tick=%b sat=%b st=%0d",
               g.rec, g.tick, g.sat, g.st, e.rec, e.tick, e.sat, e.st);
    end
  endtask

  initial begin
    test_reset();
    test_first_increment();
    test_stop_resume();
    test_power_off();
    test_saturation();
    test_clear_hold();
    test_clear_vs_increment();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
